alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 142 ++++++++++++++
 tb/tb_alu_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: accepts an opcode, then operands A and B on one shared bus,
// and pulses done for one cycle with the registered result and carry/borrow flag.
module alu_seq #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  opcode_valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned SUM_W = DATA_WIDTH + 1;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPA  = 3'd1,
    OPB  = 3'd2,
    EXEC = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e                state_q,    state_d;
  logic [OP_W-1:0]       op_q,       op_d;
  logic [DATA_WIDTH-1:0] a_q,        a_d;
  logic [DATA_WIDTH-1:0] b_q,        b_d;
  logic [DATA_WIDTH-1:0] result_q,   result_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q,     done_d;

  logic [OP_W-1:0]       new_op;
  logic                  new_op_legal;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      diff;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_ov;

  assign new_op       = data[OP_W-1:0];
  assign new_op_legal = (new_op <= OP_XOR);

  // Datapath; the top bit of the widened subtraction is the unsigned borrow.
  always_comb begin
    sum     = SUM_W'(a_q) + SUM_W'(b_q);
    diff    = SUM_W'(a_q) - SUM_W'(b_q);
    alu_res = '0;
    alu_ov  = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[DATA_WIDTH-1:0];
        alu_ov  = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_res = diff[DATA_WIDTH-1:0];
        alu_ov  = diff[DATA_WIDTH];
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  // Next state; an opcode during OPA/OPB aborts the operation in flight.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = '0;
    overflow_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (opcode_valid && new_op_legal) begin
          op_d    = new_op;
          state_d = OPA;
        end else begin
          state_d = IDLE;
        end
      end
      OPA: begin
        if (opcode_valid) begin
          if (new_op_legal) op_d = new_op;
          state_d = new_op_legal ? OPA : IDLE;
        end else begin
          a_d     = data;
          state_d = OPB;
        end
      end
      OPB: begin
        if (opcode_valid) begin
          if (new_op_legal) op_d = new_op;
          state_d = new_op_legal ? OPA : IDLE;
        end else begin
          b_d     = data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d   = alu_res;
        overflow_d = alu_ov;
        done_d     = 1'b1;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus randomized operations checked
// against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          reset_n;
  logic          opcode_valid;
  logic [DW-1:0] data;
  logic [DW-1:0] result;
  logic          overflow;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  alu_seq #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode_valid (opcode_valid),
    .data         (data),
    .result       (result),
    .overflow     (overflow),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one bus word, let one rising edge take it, sample 1ns later.
  task automatic drive(input logic v, input logic [DW-1:0] d);
    opcode_valid = v;
    data         = d;
    @(posedge clk);
    #1;
  endtask

  // Opcode, A, B, then the execute cycle; returns while done should be high.
  task automatic issue(input logic [DW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    drive(1'b1, op);
    drive(1'b0, a);
    drive(1'b0, b);
    chk("no_done_in_exec", 32'(done), 32'd0);
    drive(1'b0, DW'($urandom));
  endtask

  function automatic void model(input int op, input int a, input int b,
                                output logic [DW-1:0] res, output logic ov);
    int full;
    full = 1 << DW;
    res  = '0;
    ov   = 1'b0;
    case (op)
      0: begin res = DW'((a + b) % full); ov = (a + b) >= full; end
      1: begin res = DW'((a - b + full) % full); ov = (a < b); end
      2: res = DW'(a & b);
      3: res = DW'(a | b);
      4: res = DW'(a ^ b);
      default: res = '0;
    endcase
  endfunction

  task automatic chk_done(input string tag, input logic [DW-1:0] r, input logic ov);
    chk({tag, "_done"},   32'(done),     32'd1);
    chk({tag, "_result"}, 32'(result),   32'(r));
    chk({tag, "_ovf"},    32'(overflow), 32'(ov));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_done0"},   32'(done),     32'd0);
    chk({tag, "_result0"}, 32'(result),   32'd0);
    chk({tag, "_ovf0"},    32'(overflow), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] er;
    logic          eo;
    int            op, a, b, gap;

    reset_n      = 1'b0;
    opcode_valid = 1'b0;
    data         = '0;
    #1;
    chk_quiet("reset");
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // ADD with carry, then outputs return to zero
    issue(8'h00, 8'hF0, 8'h20);
    chk_done("add_carry", 8'h10, 1'b1);
    drive(1'b0, 8'h00);
    chk_quiet("add_after");

    // SUB with and without borrow
    issue(8'h01, 8'h05, 8'h07);
    chk_done("sub_borrow", 8'hFE, 1'b1);
    issue(8'h01, 8'h07, 8'h05);
    chk_done("sub_noborrow", 8'h02, 1'b0);
    drive(1'b0, 8'h00);

    // XOR, then OR whose opcode arrives in the XOR done cycle
    issue(8'h04, 8'hAA, 8'h0F);
    chk_done("xor", 8'hA5, 1'b0);
    drive(1'b1, 8'h03);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_gap_done0", 32'(done), 32'd0);
      drive(1'b0, (i == 0) ? 8'h30 : 8'h03);
    end
    chk_done("or_b2b", 8'h33, 1'b0);
    drive(1'b0, 8'h00);

    // Abort: a new opcode in place of B restarts with AND; upper opcode bits ignored
    drive(1'b1, 8'h00);
    drive(1'b0, 8'h01);
    drive(1'b1, 8'hF2);
    chk("abort_no_done", 32'(done), 32'd0);
    issue_tail: begin
      drive(1'b0, 8'hFF);
      drive(1'b0, 8'h3C);
      chk("abort_exec_done0", 32'(done), 32'd0);
      drive(1'b0, 8'h00);
    end
    chk_done("abort_and", 8'h3C, 1'b0);
    drive(1'b0, 8'h00);
    chk_quiet("abort_single");

    // Reserved opcode is ignored; following operands do nothing
    drive(1'b1, 8'h07);
    drive(1'b0, 8'h11);
    drive(1'b0, 8'h22);
    for (int i = 0; i < 10; i++) begin
      chk_quiet("reserved");
      drive(1'b0, DW'($urandom));
    end

    // Reset asserted while done is high clears outputs without a clock edge
    issue(8'h02, 8'hF0, 8'h3C);
    chk_done("pre_reset", 8'h30, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk_quiet("async_reset_done");
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Reset in EXEC of ADD 0xFF+0x01 discards it
    drive(1'b1, 8'h00);
    drive(1'b0, 8'hFF);
    drive(1'b0, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk_quiet("reset_in_exec");
    @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00);
      chk_quiet("post_reset_idle");
    end
    issue(8'h00, 8'h01, 8'h01);
    chk_done("add_after_reset", 8'h02, 1'b0);

    // Randomized legal operations with random idle gaps (gap 0 = back-to-back)
    for (int n = 0; n < 40; n++) begin
      op  = int'($urandom_range(0, 4));
      a   = int'($urandom_range(0, 255));
      b   = int'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) drive(1'b0, DW'($urandom));
      if (gap > 0) chk("rand_gap_done0", 32'(done), 32'd0);
      issue(DW'(op) | (DW'($urandom_range(0, 31)) << 3), DW'(a), DW'(b));
      model(op, a, b, er, eo);
      chk_done($sformatf("rand_op%0d", op), er, eo);
    end
    drive(1'b0, 8'h00);
    chk_quiet("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
